gat_feat_streamer: RTL

//  Downstream drain stage of the GAT accelerator. After gat_ready rises, reads every word of the
//  new-feature BRAM through the port-B byte-address interface and emits the words as a

---
 rtl/gat_feat_pkg.sv | 28 ++
 rtl/gat_feat_fifo2.sv | 74 +++++++
 rtl/gat_feat_streamer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gat_feat_pkg.sv
// Shared constants, FSM encodings and width helper for the GAT feature streamer.
// Default sizes match the full accelerator build; the top re-derives widths from its own parameters.
package gat_feat_pkg;

    localparam int DEF_NEW_FEATURE_WIDTH  = 32;
    localparam int DEF_NUM_SUBGRAPHS      = 2708;
    localparam int DEF_NUM_FEATURE_OUT    = 16;
    localparam int DEF_NEW_FEATURE_DEPTH  = DEF_NUM_SUBGRAPHS * DEF_NUM_FEATURE_OUT;
    localparam int NEW_FEATURE_ADDR_W     = $clog2(DEF_NEW_FEATURE_DEPTH);
    localparam int BRAM_RD_LAT            = 1;
    localparam int FIFO_DEPTH             = 2;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_READ  = 3'd1;
    localparam state_t ST_DRAIN = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_ARMED = 3'd4;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FEAT_IDX_W = idx_width(DEF_NUM_FEATURE_OUT);
    localparam int NODE_IDX_W = idx_width(DEF_NUM_SUBGRAPHS);

endpackage

// File: rtl/gat_feat_fifo2.sv
// Two-entry skid FIFO; the head always sits in slot0 so the stream outputs come straight from flops.
module gat_feat_fifo2
    import gat_feat_pkg::*;
#(
    parameter int W = DEF_NEW_FEATURE_WIDTH + 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;
    logic         valid_q, valid_d;

    // Next-state: upstream never pushes into a full FIFO without a simultaneous pop.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_d = din_i;
                end else begin
                    slot1_d = din_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    slot0_d = din_i;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = din_i;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
        valid_d = (count_d != 2'd0);
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q <= {W{1'b0}};
            slot1_q <= {W{1'b0}};
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign dout_o  = slot0_q;
    assign valid_o = valid_q;
    assign count_o = count_q;

endmodule

// File: rtl/gat_feat_streamer.sv
// Drains the new-feature BRAM as a backpressured valid/ready burst after gat_ready rises.
// Optional per-node argmax classifier outputs are enabled with `define GAT_FEAT_ARGMAX_EN.
module gat_feat_streamer
    import gat_feat_pkg::*;
#(
    parameter int  NEW_FEATURE_WIDTH = DEF_NEW_FEATURE_WIDTH,
    parameter int  NUM_SUBGRAPHS     = DEF_NUM_SUBGRAPHS,
    parameter int  NUM_FEATURE_OUT   = DEF_NUM_FEATURE_OUT,
    localparam int DEPTH             = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    localparam int ADDR_W            = $clog2(DEPTH),
    localparam int F_W               = idx_width(NUM_FEATURE_OUT),
    localparam int N_W               = idx_width(NUM_SUBGRAPHS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         gat_ready,
    output logic [ADDR_W+1:0]            feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0] feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0] m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         m_tuser,
    output logic                         m_tlast,
    output logic                         busy,
    output logic                         done
`ifdef GAT_FEAT_ARGMAX_EN
    ,
    output logic                         cls_valid,
    output logic [F_W-1:0]               cls_idx,
    output logic [N_W-1:0]               cls_node
`endif
);

    localparam int W      = NEW_FEATURE_WIDTH;
    localparam int WIDX_W = ADDR_W + 1;
    localparam logic [WIDX_W-1:0] LAST_WORD  = WIDX_W'(DEPTH - 1);
    localparam logic [WIDX_W-1:0] WORD_ONE   = WIDX_W'(1);
    localparam logic [F_W-1:0]    FEAT_LAST  = F_W'(NUM_FEATURE_OUT - 1);
    localparam logic [F_W-1:0]    FEAT_ONE   = F_W'(1);
    localparam logic [1:0]        FIFO_SLOTS = 2'(FIFO_DEPTH);

    state_t              state_q, state_d;
    logic                gat_q, seen_q;
    logic [WIDX_W-1:0]   word_idx_q, word_idx_d, word_nxt_s;
    logic [F_W-1:0]      feat_idx_q, feat_idx_d;
    logic [ADDR_W+1:0]   addrb_q, addrb_d;
    logic                infl_q, infl_d, infl_user_q, infl_user_d, infl_last_q, infl_last_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                start_s, pop_s, room_s, issue_s;
    logic [1:0]          fifo_count_s, used_s;
    logic [W+1:0]        head_s;

    // The edge detector ignores the first sampled level so a high gat_ready out of reset starts nothing.
    assign start_s    = seen_q & gat_ready & ~gat_q;
    assign pop_s      = m_tvalid & m_tready;
    assign word_nxt_s = word_idx_q + WORD_ONE;

    // Issue control: a slot freed by this cycle's handshake counts as room, keeping 1 word/cycle.
    always_comb begin
        used_s  = fifo_count_s + {1'b0, infl_q};
        room_s  = pop_s ? (used_s <= FIFO_SLOTS) : (used_s < FIFO_SLOTS);
        issue_s = (state_q == ST_READ) && room_s;
    end

    // FSM and counters; addrb always holds the address the BRAM will read at the next edge.
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        feat_idx_d  = feat_idx_q;
        addrb_d     = addrb_q;
        infl_d      = issue_s;
        infl_user_d = (feat_idx_q == FEAT_LAST);
        infl_last_d = (word_idx_q == LAST_WORD);
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d    = ST_READ;
                    word_idx_d = {WIDX_W{1'b0}};
                    feat_idx_d = {F_W{1'b0}};
                    addrb_d    = {(ADDR_W + 2){1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (issue_s) begin
                    word_idx_d = word_nxt_s;
                    feat_idx_d = (feat_idx_q == FEAT_LAST) ? {F_W{1'b0}} : feat_idx_q + FEAT_ONE;
                    if (word_idx_q == LAST_WORD) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addrb_d = {word_nxt_s[ADDR_W-1:0], 2'b00};
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (pop_s && m_tlast) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d    = ST_ARMED;
                word_idx_d = {WIDX_W{1'b0}};
                feat_idx_d = {F_W{1'b0}};
                addrb_d    = {(ADDR_W + 2){1'b0}};
            end
            ST_ARMED: begin
                if (!gat_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_READ) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // Control, counter and read-pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gat_q       <= 1'b0;
            seen_q      <= 1'b0;
            word_idx_q  <= {WIDX_W{1'b0}};
            feat_idx_q  <= {F_W{1'b0}};
            addrb_q     <= {(ADDR_W + 2){1'b0}};
            infl_q      <= 1'b0;
            infl_user_q <= 1'b0;
            infl_last_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gat_q       <= gat_ready;
            seen_q      <= 1'b1;
            word_idx_q  <= word_idx_d;
            feat_idx_q  <= feat_idx_d;
            addrb_q     <= addrb_d;
            infl_q      <= infl_d;
            infl_user_q <= infl_user_d;
            infl_last_q <= infl_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    gat_feat_fifo2 #(
        .W (W + 2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (infl_q),
        .din_i   ({feat_bram_dout, infl_user_q, infl_last_q}),
        .pop_i   (pop_s),
        .dout_o  (head_s),
        .valid_o (m_tvalid),
        .count_o (fifo_count_s)
    );

    assign m_tdata         = head_s[W+1:2];
    assign m_tuser         = head_s[1];
    assign m_tlast         = head_s[0];
    assign feat_bram_addrb = addrb_q;
    assign busy            = busy_q;
    assign done            = done_q;

`ifdef GAT_FEAT_ARGMAX_EN
    logic [F_W-1:0]        out_feat_q, out_feat_d, max_idx_q, max_idx_d, cand_idx_s;
    logic [N_W-1:0]        out_node_q, out_node_d;
    logic signed [W-1:0]   max_q, max_d;
    logic                  take_s;
    logic                  cls_valid_q, cls_valid_d;
    logic [F_W-1:0]        cls_idx_q, cls_idx_d;
    logic [N_W-1:0]        cls_node_q, cls_node_d;

    // Running signed max over handshaken words; only a strictly greater value moves the index.
    always_comb begin
        out_feat_d  = out_feat_q;
        out_node_d  = out_node_q;
        max_d       = max_q;
        max_idx_d   = max_idx_q;
        cls_valid_d = 1'b0;
        cls_idx_d   = cls_idx_q;
        cls_node_d  = cls_node_q;
        take_s      = (out_feat_q == {F_W{1'b0}}) || ($signed(m_tdata) > max_q);
        cand_idx_s  = take_s ? out_feat_q : max_idx_q;
        if ((state_q == ST_IDLE) && start_s) begin
            out_feat_d = {F_W{1'b0}};
            out_node_d = {N_W{1'b0}};
        end else if (pop_s) begin
            max_d     = take_s ? $signed(m_tdata) : max_q;
            max_idx_d = cand_idx_s;
            if (out_feat_q == FEAT_LAST) begin
                out_feat_d  = {F_W{1'b0}};
                out_node_d  = out_node_q + N_W'(1);
                cls_valid_d = 1'b1;
                cls_idx_d   = cand_idx_s;
                cls_node_d  = out_node_q;
            end else begin
                out_feat_d = out_feat_q + FEAT_ONE;
            end
        end else begin
            out_feat_d = out_feat_q;
        end
    end

    // Argmax tracking and classifier output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_feat_q  <= {F_W{1'b0}};
            out_node_q  <= {N_W{1'b0}};
            max_q       <= {W{1'b0}};
            max_idx_q   <= {F_W{1'b0}};
            cls_valid_q <= 1'b0;
            cls_idx_q   <= {F_W{1'b0}};
            cls_node_q  <= {N_W{1'b0}};
        end else begin
            out_feat_q  <= out_feat_d;
            out_node_q  <= out_node_d;
            max_q       <= max_d;
            max_idx_q   <= max_idx_d;
            cls_valid_q <= cls_valid_d;
            cls_idx_q   <= cls_idx_d;
            cls_node_q  <= cls_node_d;
        end
    end

    assign cls_valid = cls_valid_q;
    assign cls_idx   = cls_idx_q;
    assign cls_node  = cls_node_q;
`endif

endmodule
